id_ex_hazard_stage: RTL and testbench

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/hazard_unit.sv | 57 +++++
 rtl/id_ex_hazard_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage and its hazard unit.
//   FWD_*      : ALU operand forward selects (register file, WB, MEM).
//   RES_*      : ResultSrc encodings carried down the pipe.
//   ex_ctrl_t  : control fields held in the EX stage register.
//   fwd_select : forwarding priority for one EX source register.
package pipe_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef struct packed {
      logic       branch;
      logic       mem_write;
      logic       mem_read;
      logic       alu_src;
      logic       reg_write;
      logic       jump;
      logic [1:0] result_src;
      logic [2:0] alu_control;
   } ex_ctrl_t;

   // MEM is the younger producer, so it beats WB. x0 is never forwarded.
   function automatic logic [1:0] fwd_select(input logic       reg_write_m,
                                             input logic [4:0] rd_m,
                                             input logic       reg_write_w,
                                             input logic [4:0] rd_w,
                                             input logic [4:0] rs_e);
      logic [1:0] sel;
      sel = FWD_REG;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
         sel = FWD_MEM;
      end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection and operand forwarding.
//   Inputs : EX-stage state (valid, mem_read, branch, jump, zero, rs1/rs2/rd),
//            decode sources rs1/rs2, MEM and WB writeback info.
//   Outputs: lw_stall, pc_src, stall_f/stall_d, flush_d, flush_e,
//            forward_a/forward_b operand selects.
module hazard_unit
   import pipe_pkg::*;
(
   input  logic       valid_e_i,
   input  logic       mem_read_e_i,
   input  logic       branch_e_i,
   input  logic       jump_e_i,
   input  logic       zero_e_i,
   input  logic [4:0] rs1_d_i,
   input  logic [4:0] rs2_d_i,
   input  logic [4:0] rs1_e_i,
   input  logic [4:0] rs2_e_i,
   input  logic [4:0] rd_e_i,
   input  logic       reg_write_m_i,
   input  logic [4:0] rd_m_i,
   input  logic       reg_write_w_i,
   input  logic [4:0] rd_w_i,
   output logic       lw_stall_o,
   output logic       pc_src_o,
   output logic       stall_f_o,
   output logic       stall_d_o,
   output logic       flush_d_o,
   output logic       flush_e_o,
   output logic [1:0] forward_a_o,
   output logic [1:0] forward_b_o
);

   always_comb begin
      lw_stall_o  = 1'b0;
      pc_src_o    = 1'b0;
      stall_f_o   = 1'b0;
      stall_d_o   = 1'b0;
      flush_d_o   = 1'b0;
      flush_e_o   = 1'b0;
      forward_a_o = FWD_REG;
      forward_b_o = FWD_REG;

      lw_stall_o = valid_e_i && mem_read_e_i && (rd_e_i != 5'd0) &&
                   ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
      pc_src_o   = valid_e_i && ((branch_e_i && zero_e_i) || jump_e_i);

      // A redirect squashes the dependent instruction anyway, so it overrides the stall.
      stall_f_o  = lw_stall_o && !pc_src_o;
      stall_d_o  = stall_f_o;
      flush_d_o  = pc_src_o;
      flush_e_o  = lw_stall_o || pc_src_o;

      forward_a_o = fwd_select(reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i, rs1_e_i);
      forward_b_o = fwd_select(reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i, rs2_e_i);
   end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with hazard steering and a saturating bubble counter.
//   clk, reset        : clock and asynchronous active-high reset.
//   *D inputs         : decoded control and register addresses from ID.
//   ZeroE             : ALU zero flag of the instruction in EX.
//   RegWriteM/RdM/W   : writeback info used for forwarding.
//   *E outputs        : registered EX copies; ValidE marks a real instruction.
//   PCSrcE, StallF/D, FlushD, ForwardAE/BE : pipeline steering.
//   BubbleCnt         : load-use bubbles inserted, saturating at 16'hFFFF.
module id_ex_hazard_stage
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        BranchD,
   input  logic        MemWriteD,
   input  logic        MemReadD,
   input  logic        ALUSrcD,
   input  logic        RegWriteD,
   input  logic        JumpD,
   input  logic [1:0]  ResultSrcD,
   input  logic [2:0]  ALUControlD,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  RdD,
   input  logic        ZeroE,
   input  logic        RegWriteM,
   input  logic [4:0]  RdM,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   output logic        BranchE,
   output logic        MemWriteE,
   output logic        MemReadE,
   output logic        ALUSrcE,
   output logic        RegWriteE,
   output logic        JumpE,
   output logic [1:0]  ResultSrcE,
   output logic [2:0]  ALUControlE,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [4:0]  RdE,
   output logic        ValidE,
   output logic        PCSrcE,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic [15:0] BubbleCnt
);

   ex_ctrl_t    ctrl_d, ctrl_q;
   logic [4:0]  rs1_d, rs1_q;
   logic [4:0]  rs2_d, rs2_q;
   logic [4:0]  rd_d, rd_q;
   logic        valid_d, valid_q;
   logic [15:0] bubble_cnt_d, bubble_cnt_q;

   logic        lw_stall;
   logic        flush_e;

   hazard_unit u_hazard_unit (
      .valid_e_i     (valid_q),
      .mem_read_e_i  (ctrl_q.mem_read),
      .branch_e_i    (ctrl_q.branch),
      .jump_e_i      (ctrl_q.jump),
      .zero_e_i      (ZeroE),
      .rs1_d_i       (Rs1D),
      .rs2_d_i       (Rs2D),
      .rs1_e_i       (rs1_q),
      .rs2_e_i       (rs2_q),
      .rd_e_i        (rd_q),
      .reg_write_m_i (RegWriteM),
      .rd_m_i        (RdM),
      .reg_write_w_i (RegWriteW),
      .rd_w_i        (RdW),
      .lw_stall_o    (lw_stall),
      .pc_src_o      (PCSrcE),
      .stall_f_o     (StallF),
      .stall_d_o     (StallD),
      .flush_d_o     (FlushD),
      .flush_e_o     (flush_e),
      .forward_a_o   (ForwardAE),
      .forward_b_o   (ForwardBE)
   );

   always_comb begin
      ctrl_d       = '0;
      rs1_d        = 5'd0;
      rs2_d        = 5'd0;
      rd_d         = 5'd0;
      valid_d      = 1'b0;
      bubble_cnt_d = bubble_cnt_q;

      // A flushed slot becomes an all-zero bubble; otherwise take the D instruction.
      if (!flush_e) begin
         ctrl_d.branch      = BranchD;
         ctrl_d.mem_write   = MemWriteD;
         ctrl_d.mem_read    = MemReadD;
         ctrl_d.alu_src     = ALUSrcD;
         ctrl_d.reg_write   = RegWriteD;
         ctrl_d.jump        = JumpD;
         ctrl_d.result_src  = ResultSrcD;
         ctrl_d.alu_control = ALUControlD;
         rs1_d              = Rs1D;
         rs2_d              = Rs2D;
         rd_d               = RdD;
         valid_d            = 1'b1;
      end

      if (lw_stall && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q       <= '0;
         rs1_q        <= 5'd0;
         rs2_q        <= 5'd0;
         rd_q         <= 5'd0;
         valid_q      <= 1'b0;
         bubble_cnt_q <= 16'd0;
      end else begin
         ctrl_q       <= ctrl_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         valid_q      <= valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign BranchE     = ctrl_q.branch;
   assign MemWriteE   = ctrl_q.mem_write;
   assign MemReadE    = ctrl_q.mem_read;
   assign ALUSrcE     = ctrl_q.alu_src;
   assign RegWriteE   = ctrl_q.reg_write;
   assign JumpE       = ctrl_q.jump;
   assign ResultSrcE  = ctrl_q.result_src;
   assign ALUControlE = ctrl_q.alu_control;
   assign Rs1E        = rs1_q;
   assign Rs2E        = rs2_q;
   assign RdE         = rd_q;
   assign ValidE      = valid_q;
   assign BubbleCnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed scenarios plus a randomized
// run against a behavioural model of the EX slot and bubble count.
module tb_id_ex_hazard_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        BranchD, MemWriteD, MemReadD, ALUSrcD, RegWriteD, JumpD;
   logic [1:0]  ResultSrcD;
   logic [2:0]  ALUControlD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        ZeroE;
   logic        RegWriteM, RegWriteW;
   logic [4:0]  RdM, RdW;
   logic        BranchE, MemWriteE, MemReadE, ALUSrcE, RegWriteE, JumpE;
   logic [1:0]  ResultSrcE;
   logic [2:0]  ALUControlE;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic        ValidE, PCSrcE, StallF, StallD, FlushD;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] BubbleCnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_hazard_stage dut (
      .clk(clk), .reset(reset),
      .BranchD(BranchD), .MemWriteD(MemWriteD), .MemReadD(MemReadD), .ALUSrcD(ALUSrcD),
      .RegWriteD(RegWriteD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
      .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
      .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
      .BranchE(BranchE), .MemWriteE(MemWriteE), .MemReadE(MemReadE), .ALUSrcE(ALUSrcE),
      .RegWriteE(RegWriteE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
      .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BubbleCnt(BubbleCnt)
   );

   // ---------------- behavioural model of the EX slot ----------------
   // ctrl bit layout: 10 branch, 9 memwrite, 8 memread, 7 alusrc, 6 regwrite, 5 jump,
   // 4:3 resultsrc, 2:0 alucontrol
   logic [10:0] m_ctrl;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic        m_valid;
   logic [15:0] m_cnt;

   function automatic logic model_lw();
      return m_valid && m_ctrl[8] && (m_rd != 0) && ((m_rd == Rs1D) || (m_rd == Rs2D));
   endfunction

   function automatic logic model_pc();
      return m_valid && ((m_ctrl[10] && ZeroE) || m_ctrl[5]);
   endfunction

   function automatic logic [1:0] model_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ctrl <= '0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_valid <= 1'b0; m_cnt <= '0;
      end else begin
         if (model_lw() || model_pc()) begin
            m_ctrl <= '0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_valid <= 1'b0;
         end else begin
            m_ctrl  <= {BranchD, MemWriteD, MemReadD, ALUSrcD, RegWriteD, JumpD,
                        ResultSrcD, ALUControlD};
            m_rs1   <= Rs1D; m_rs2 <= Rs2D; m_rd <= RdD; m_valid <= 1'b1;
         end
         if (model_lw() && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
   end

   function automatic logic [10:0] dut_ctrl();
      return {BranchE, MemWriteE, MemReadE, ALUSrcE, RegWriteE, JumpE, ResultSrcE, ALUControlE};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      BranchD = 0; MemWriteD = 0; MemReadD = 0; ALUSrcD = 0; RegWriteD = 0; JumpD = 0;
      ResultSrcD = 0; ALUControlD = 0; Rs1D = 0; Rs2D = 0; RdD = 0; ZeroE = 0;
      RegWriteM = 0; RdM = 0; RegWriteW = 0; RdW = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_idle();
      reset = 1'b1;
      BranchD = 1; MemReadD = 1; RegWriteD = 1; JumpD = 1; RdD = 5'd9; Rs1D = 5'd9;
      RegWriteM = 1; RdM = 5'd0;
      tick(); tick();
      checks++;
      if ({dut_ctrl(), Rs1E, Rs2E, RdE} !== 26'd0) begin
         errors++; $display("FAIL reset_e_regs: got %h expected 0", {dut_ctrl(), Rs1E, Rs2E, RdE});
      end
      checks++;
      if ({ValidE, BubbleCnt} !== 17'd0) begin
         errors++; $display("FAIL reset_valid_cnt: got %h expected 0", {ValidE, BubbleCnt});
      end
      checks++;
      if ({PCSrcE, StallF, StallD, FlushD, ForwardAE, ForwardBE} !== 8'd0) begin
         errors++;
         $display("FAIL reset_comb: got %b expected 0",
                  {PCSrcE, StallF, StallD, FlushD, ForwardAE, ForwardBE});
      end
      reset = 1'b0;
      set_idle();
      #1;
   endtask

   task automatic test_plain_capture();
      do_reset();
      RegWriteD = 1; ALUControlD = 3'b010; RdD = 5'd5; Rs1D = 5'd1; Rs2D = 5'd2;
      tick();
      checks++;
      if ({RegWriteE, ALUControlE, RdE, ValidE} !== {1'b1, 3'b010, 5'd5, 1'b1}) begin
         errors++;
         $display("FAIL plain_capture: got %b expected %b",
                  {RegWriteE, ALUControlE, RdE, ValidE}, {1'b1, 3'b010, 5'd5, 1'b1});
      end
   endtask

   task automatic test_load_use();
      do_reset();
      MemReadD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5'd7; Rs1D = 5'd1; Rs2D = 5'd2;
      tick();
      MemReadD = 0; ResultSrcD = 0; RdD = 5'd8; Rs1D = 5'd7; Rs2D = 5'd3;
      #1;
      checks++;
      if ({StallF, StallD, FlushD} !== 3'b110) begin
         errors++; $display("FAIL load_use_stall: got %b expected 110", {StallF, StallD, FlushD});
      end
      tick();
      checks++;
      if ({ValidE, RdE, BubbleCnt} !== {1'b0, 5'd0, 16'd1}) begin
         errors++;
         $display("FAIL load_use_bubble: valid=%b rd=%0d cnt=%0d expected 0 0 1",
                  ValidE, RdE, BubbleCnt);
      end
      tick();
      checks++;
      if ({ValidE, RdE, Rs1E, BubbleCnt} !== {1'b1, 5'd8, 5'd7, 16'd1}) begin
         errors++;
         $display("FAIL load_use_resume: valid=%b rd=%0d rs1=%0d cnt=%0d expected 1 8 7 1",
                  ValidE, RdE, Rs1E, BubbleCnt);
      end
   endtask

   task automatic test_x0_no_hazard();
      do_reset();
      MemReadD = 1; RegWriteD = 1; RdD = 5'd0;
      tick();
      MemReadD = 0; Rs1D = 5'd0; Rs2D = 5'd0; RegWriteM = 1; RdM = 5'd0;
      RegWriteW = 1; RdW = 5'd0;
      #1;
      checks++;
      if ({StallF, ForwardAE, ForwardBE} !== 5'd0) begin
         errors++;
         $display("FAIL x0_no_hazard: got %b expected 0", {StallF, ForwardAE, ForwardBE});
      end
   endtask

   task automatic test_branch();
      do_reset();
      BranchD = 1; Rs1D = 5'd1; Rs2D = 5'd2;
      tick();
      BranchD = 0; RegWriteD = 1; RdD = 5'd4; ZeroE = 0;
      #1;
      checks++;
      if ({PCSrcE, FlushD} !== 2'b00) begin
         errors++; $display("FAIL branch_not_taken: got %b expected 00", {PCSrcE, FlushD});
      end
      ZeroE = 1;
      #1;
      checks++;
      if ({PCSrcE, FlushD, StallF} !== 3'b110) begin
         errors++; $display("FAIL branch_taken: got %b expected 110", {PCSrcE, FlushD, StallF});
      end
      tick();
      checks++;
      if ({ValidE, RdE, RegWriteE} !== 7'd0) begin
         errors++; $display("FAIL branch_bubble: got %b expected 0", {ValidE, RdE, RegWriteE});
      end
   endtask

   task automatic test_flush_wins();
      do_reset();
      BranchD = 1; MemReadD = 1; RdD = 5'd9;
      tick();
      BranchD = 0; MemReadD = 0; RdD = 5'd2; Rs1D = 5'd9; ZeroE = 1;
      #1;
      checks++;
      if ({StallF, StallD, FlushD, PCSrcE} !== 4'b0011) begin
         errors++;
         $display("FAIL flush_wins: got %b expected 0011", {StallF, StallD, FlushD, PCSrcE});
      end
      tick();
      checks++;
      if ({ValidE, BubbleCnt} !== {1'b0, 16'd1}) begin
         errors++;
         $display("FAIL flush_wins_bubble: valid=%b cnt=%0d expected 0 1", ValidE, BubbleCnt);
      end
   endtask

   task automatic test_forward_priority();
      do_reset();
      Rs1D = 5'd3; Rs2D = 5'd3;
      tick();
      RegWriteM = 1; RdM = 5'd3; RegWriteW = 1; RdW = 5'd3;
      #1;
      checks++;
      if ({ForwardAE, ForwardBE} !== 4'b1010) begin
         errors++; $display("FAIL fwd_mem: got %b expected 1010", {ForwardAE, ForwardBE});
      end
      RdM = 5'd0;
      #1;
      checks++;
      if (ForwardAE !== 2'b01) begin
         errors++; $display("FAIL fwd_wb: got %b expected 01", ForwardAE);
      end
      RdW = 5'd0;
      #1;
      checks++;
      if (ForwardAE !== 2'b00) begin
         errors++; $display("FAIL fwd_reg: got %b expected 00", ForwardAE);
      end
      RegWriteM = 0; RdM = 5'd3; RdW = 5'd3;
      #1;
      checks++;
      if (ForwardBE !== 2'b01) begin
         errors++; $display("FAIL fwd_m_disabled: got %b expected 01", ForwardBE);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         BranchD = $urandom_range(0, 3) == 0; MemWriteD = $urandom_range(0, 1) == 1;
         MemReadD = $urandom_range(0, 1) == 1; ALUSrcD = $urandom_range(0, 1) == 1;
         RegWriteD = $urandom_range(0, 1) == 1; JumpD = $urandom_range(0, 7) == 0;
         ResultSrcD = 2'($urandom_range(0, 3)); ALUControlD = 3'($urandom_range(0, 7));
         Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
         RdD = 5'($urandom_range(0, 7)); ZeroE = $urandom_range(0, 1) == 1;
         RegWriteM = $urandom_range(0, 1) == 1; RdM = 5'($urandom_range(0, 7));
         RegWriteW = $urandom_range(0, 1) == 1; RdW = 5'($urandom_range(0, 7));
         #1;
         checks++;
         if ({PCSrcE, StallF, StallD, FlushD, ForwardAE, ForwardBE} !==
             {model_pc(), model_lw() && !model_pc(), model_lw() && !model_pc(), model_pc(),
              model_fwd(Rs1E), model_fwd(Rs2E)}) begin
            errors++;
            $display("FAIL rand_comb[%0d]: got %b expected %b", i,
                     {PCSrcE, StallF, StallD, FlushD, ForwardAE, ForwardBE},
                     {model_pc(), model_lw() && !model_pc(), model_lw() && !model_pc(),
                      model_pc(), model_fwd(Rs1E), model_fwd(Rs2E)});
         end
         tick();
         checks++;
         if ({dut_ctrl(), Rs1E, Rs2E, RdE, ValidE, BubbleCnt} !==
             {m_ctrl, m_rs1, m_rs2, m_rd, m_valid, m_cnt}) begin
            errors++;
            $display("FAIL rand_regs[%0d]: got %h expected %h", i,
                     {dut_ctrl(), Rs1E, Rs2E, RdE, ValidE, BubbleCnt},
                     {m_ctrl, m_rs1, m_rs2, m_rd, m_valid, m_cnt});
         end
      end
   endtask

   task automatic test_saturation_and_async_reset();
      do_reset();
      // Preload the counter in one edge instead of spending ~131k cycles on bubbles.
      MemReadD = 1; RegWriteD = 1; RdD = 5'd7; Rs1D = 5'd1; Rs2D = 5'd2;
      force dut.bubble_cnt_d = 16'hFFFF;
      tick();
      release dut.bubble_cnt_d;
      MemReadD = 0; RdD = 5'd4; Rs1D = 5'd7; Rs2D = 5'd0;
      #1;
      checks++;
      if ({BubbleCnt, StallF} !== {16'hFFFF, 1'b1}) begin
         errors++;
         $display("FAIL sat_preload: cnt=%h stall=%b expected ffff 1", BubbleCnt, StallF);
      end
      tick();
      checks++;
      if ({BubbleCnt, ValidE} !== {16'hFFFF, 1'b0}) begin
         errors++;
         $display("FAIL sat_hold: cnt=%h valid=%b expected ffff 0", BubbleCnt, ValidE);
      end
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({BubbleCnt, ValidE, RdE} !== 22'd0) begin
         errors++;
         $display("FAIL async_reset: cnt=%h valid=%b rd=%0d expected 0 0 0",
                  BubbleCnt, ValidE, RdE);
      end
      reset = 1'b0;
      set_idle();
      #1;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      MemReadD = 1; RegWriteD = 1; RdD = 5'd7;
      tick();
      MemReadD = 0; RdD = 5'd11; Rs1D = 5'd7; Rs2D = 5'd6; ALUControlD = 3'b110;
      #1;
      checks++;
      if (StallF !== 1'b1) begin
         errors++; $display("FAIL mid_stall_setup: got %b expected 1", StallF);
      end
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      checks++;
      if ({ValidE, RdE, Rs1E, ALUControlE, BubbleCnt} !==
          {1'b1, 5'd11, 5'd7, 3'b110, 16'd0}) begin
         errors++;
         $display("FAIL reset_mid_stall: valid=%b rd=%0d rs1=%0d alu=%b cnt=%0d expected 1 11 7 110 0",
                  ValidE, RdE, Rs1E, ALUControlE, BubbleCnt);
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_plain_capture();
      test_load_use();
      test_x0_no_hazard();
      test_branch();
      test_flush_wins();
      test_forward_priority();
      test_random();
      test_saturation_and_async_reset();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
